// File: rtl/fib_sequencer.sv
// fib_sequencer: streams ROM words 0..LAST_ADDR through a valid/ready output register.
// Define FIB_CHECK_EN to add a sticky err flag that checks each word is the sum of the previous two.
module fib_sequencer #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 6,
    parameter int LAST_ADDR = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              loop,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              w_xfer, w_cap, w_last;

    assign w_xfer = r_valid && out_ready;
    assign w_last = r_addr == ADDR_W'(LAST_ADDR);
    // Abort suppresses any capture so the pass dies cleanly on that edge.
    assign w_cap  = !abort && (r_state == RUN || (r_state == IDLE && start)) && (!r_valid || w_xfer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_cap) w_next = (w_last && !loop) ? DRAIN : RUN;
            RUN:   if (w_cap && w_last && !loop) w_next = DRAIN;
            DRAIN: if (w_xfer) w_next = FIN;
            FIN:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (abort) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (abort) begin
            r_addr  <= '0;
            r_valid <= 1'b0;
        end else if (w_cap) begin
            r_data  <= rom_data;
            r_valid <= 1'b1;
            r_addr  <= w_last ? '0 : r_addr + 1'b1;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    assign addr      = r_addr;
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign busy      = r_state != IDLE;
    assign done      = r_state == FIN;

`ifdef FIB_CHECK_EN
    logic [DATA_W-1:0] r_h0, r_h1;
    logic              r_err;
    logic [DATA_W:0]   w_sum;

    // Extra sum bit makes an overflowing pair a guaranteed mismatch.
    assign w_sum = {1'b0, r_h0} + {1'b0, r_h1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h0  <= '0;
            r_h1  <= '0;
            r_err <= 1'b0;
        end else if (w_cap) begin
            r_h1 <= rom_data;
            r_h0 <= (r_addr == '0) ? '0 : r_h1;
            if (r_state == IDLE)
                r_err <= 1'b0;
            else if (r_addr >= ADDR_W'(2) && w_sum != {1'b0, rom_data})
                r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_fib_sequencer.sv
// tb_fib_sequencer: randomized and directed checks of fib_sequencer against a ROM-stream reference model.
module tb_fib_sequencer;
    localparam int AW   = 4;
    localparam int DW   = 6;
    localparam int LAST = 9;
`ifdef FIB_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, start, loop, abort, out_ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] rom_data, out_data;
    logic          out_valid, busy, done, err;
    logic [DW-1:0] rom [0:LAST];
    logic [DW-1:0] got [$];
    int            checks = 0;
    int            passed = 0;

    fib_sequencer #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LAST)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .loop(loop), .abort(abort),
        .addr(addr), .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    assign rom_data = (int'(addr) <= LAST) ? rom[addr] : '0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rom_fib;
        int a = 0, b = 1, t;
        for (int i = 0; i <= LAST; i++) begin
            rom[i] = DW'(a);
            t = a + b;
            a = b;
            b = t;
        end
    endtask

    task automatic finish_pass(input string name);
        int n = 0;
        start = 0;
        abort = 0;
        out_ready = 1;
        while (busy && n < 60) begin
            tick;
            n++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL %s_drain_timeout: busy=%0b expected 0", name, busy);
        else passed++;
    endtask

    task automatic test_reset;
        rst_n = 1; start = 0; loop = 0; abort = 0; out_ready = 1;
        #2 rst_n = 0;
        #1;
        checks++;
        if ({out_valid, out_data, addr, busy, done, err} !== '0)
            $display("FAIL reset_state: valid=%0b data=%0d addr=%0d busy=%0b done=%0b err=%0b expected all 0",
                     out_valid, out_data, addr, busy, done, err);
        else passed++;
        @(negedge clk) rst_n = 1;
        tick;
    endtask

    task automatic test_basic;
        out_ready = 1; loop = 0; start = 1;
        tick;
        start = 0;
        for (int i = 0; i <= LAST; i++) begin
            checks++;
            if ({out_valid, out_data} !== {1'b1, rom[i]})
                $display("FAIL basic_word%0d: valid=%0b data=%0d expected valid=1 data=%0d", i, out_valid, out_data, rom[i]);
            else passed++;
            tick;
        end
        checks++;
        if ({done, out_valid} !== 2'b10) $display("FAIL basic_done: done=%0b valid=%0b expected 1 0", done, out_valid);
        else passed++;
        tick;
        checks++;
        if ({done, busy, err} !== 3'b000) $display("FAIL basic_end: done=%0b busy=%0b err=%0b expected 0 0 0", done, busy, err);
        else passed++;
    endtask

    task automatic test_backpressure;
        int n = 0;
        bit held = 0;
        got.delete();
        out_ready = 1; start = 1;
        tick;
        start = 0;
        while (busy && n < 100) begin
            if (!held && out_valid && out_data == rom[5]) begin
                held = 1;
                out_ready = 0;
                repeat (3) begin
                    tick;
                    checks++;
                    if ({out_valid, int'(addr), out_data} !== {1'b1, 6, rom[5]})
                        $display("FAIL stall_hold: valid=%0b addr=%0d data=%0d expected 1 6 %0d", out_valid, addr, out_data, rom[5]);
                    else passed++;
                end
                out_ready = 1;
            end
            if (out_valid && out_ready) got.push_back(out_data);
            tick;
            n++;
        end
        checks++;
        if (got.size() != LAST + 1) $display("FAIL stall_count: got %0d words expected %0d", got.size(), LAST + 1);
        else passed++;
        for (int i = 0; i < got.size() && i <= LAST; i++) begin
            checks++;
            if (got[i] !== rom[i]) $display("FAIL stall_word%0d: got %0d expected %0d", i, got[i], rom[i]);
            else passed++;
        end
    endtask

    task automatic test_random;
        for (int p = 0; p < 4; p++) begin
            int n = 0, nd = 0, bad = 0;
            got.delete();
            loop = 0; start = 1; out_ready = 1'($urandom % 2);
            tick;
            while (busy && n < 400) begin
                if (done) nd++;
                if (int'(addr) > LAST) bad++;
                out_ready = ($urandom % 4) != 0;
                start = 1'($urandom % 2);
                if (out_valid && out_ready) got.push_back(out_data);
                tick;
                n++;
            end
            start = 0;
            checks++;
            if (busy !== 1'b0) $display("FAIL rand%0d_timeout: still busy after %0d cycles", p, n);
            else passed++;
            checks++;
            if (got.size() != LAST + 1) $display("FAIL rand%0d_count: got %0d words expected %0d", p, got.size(), LAST + 1);
            else passed++;
            for (int i = 0; i < got.size() && i <= LAST; i++) begin
                checks++;
                if (got[i] !== rom[i]) $display("FAIL rand%0d_word%0d: got %0d expected %0d", p, i, got[i], rom[i]);
                else passed++;
            end
            checks++;
            if (nd != 1 || bad != 0) $display("FAIL rand%0d_done_addr: done pulses=%0d addr overruns=%0d expected 1 0", p, nd, bad);
            else passed++;
        end
    endtask

    task automatic test_loop;
        int nd = 0;
        out_ready = 1; loop = 1; start = 1;
        tick;
        start = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) nd++;
            checks++;
            if ({out_valid, out_data} !== {1'b1, rom[i % (LAST + 1)]})
                $display("FAIL loop_word%0d: valid=%0b data=%0d expected 1 %0d", i, out_valid, out_data, rom[i % (LAST + 1)]);
            else passed++;
            tick;
        end
        checks++;
        if (nd != 0) $display("FAIL loop_no_done: done pulses=%0d expected 0", nd);
        else passed++;
        abort = 1;
        tick;
        abort = 0; loop = 0;
        checks++;
        if ({busy, out_valid, addr} !== '0) $display("FAIL loop_abort: busy=%0b valid=%0b addr=%0d expected 0 0 0", busy, out_valid, addr);
        else passed++;
    endtask

    task automatic test_abort;
        int n = 0;
        out_ready = 1; start = 1;
        tick;
        start = 0;
        while (!(out_valid && out_data == rom[6]) && n < 20) begin
            tick;
            n++;
        end
        abort = 1;
        tick;
        abort = 0;
        checks++;
        if ({busy, out_valid, addr, done} !== '0)
            $display("FAIL abort_state: busy=%0b valid=%0b addr=%0d done=%0b expected all 0", busy, out_valid, addr, done);
        else passed++;
        tick;
        checks++;
        if (done !== 1'b0) $display("FAIL abort_no_done: done=%0b expected 0", done);
        else passed++;
        start = 1; abort = 1;
        tick;
        start = 0; abort = 0;
        checks++;
        if ({busy, out_valid} !== 2'b00) $display("FAIL abort_priority: busy=%0b valid=%0b expected 0 0", busy, out_valid);
        else passed++;
        start = 1;
        tick;
        start = 0;
        checks++;
        if ({out_valid, out_data} !== {1'b1, rom[0]}) $display("FAIL abort_restart: valid=%0b data=%0d expected 1 %0d", out_valid, out_data, rom[0]);
        else passed++;
        finish_pass("abort");
    endtask

    task automatic test_async_reset;
        out_ready = 1; start = 1;
        tick;
        start = 0;
        repeat (4) tick;
        #2 rst_n = 0;
        #1;
        checks++;
        if ({out_valid, out_data, addr, busy, done, err} !== '0)
            $display("FAIL async_reset: valid=%0b data=%0d addr=%0d busy=%0b done=%0b err=%0b expected all 0",
                     out_valid, out_data, addr, busy, done, err);
        else passed++;
        @(negedge clk) rst_n = 1;
        tick;
        checks++;
        if ({busy, out_valid} !== 2'b00) $display("FAIL async_idle: busy=%0b valid=%0b expected 0 0", busy, out_valid);
        else passed++;
        start = 1;
        tick;
        start = 0;
        checks++;
        if ({out_valid, out_data} !== {1'b1, rom[0]}) $display("FAIL async_restart: valid=%0b data=%0d expected 1 %0d", out_valid, out_data, rom[0]);
        else passed++;
        finish_pass("async");
    endtask

    task automatic test_err;
        logic exp_err = 1'b0;
        rom[5] = 6;
        out_ready = 1; start = 1;
        tick;
        start = 0;
        for (int i = 0; i <= LAST; i++) begin
            if (CHK && i >= 2) begin
                if ({1'b0, rom[i]} != {1'b0, rom[i-1]} + {1'b0, rom[i-2]}) exp_err = 1'b1;
            end
            checks++;
            if ({err, out_data} !== {exp_err, rom[i]})
                $display("FAIL err_word%0d: err=%0b data=%0d expected %0b %0d", i, err, out_data, exp_err, rom[i]);
            else passed++;
            tick;
        end
        tick;
        rom_fib();
        checks++;
        if (err !== exp_err) $display("FAIL err_sticky: err=%0b expected %0b", err, exp_err);
        else passed++;
        start = 1;
        tick;
        start = 0;
        checks++;
        if (err !== 1'b0) $display("FAIL err_clear: err=%0b expected 0", err);
        else passed++;
        finish_pass("err");
        checks++;
        if (err !== 1'b0) $display("FAIL err_clean_pass: err=%0b expected 0", err);
        else passed++;
    endtask

    initial begin
        rom_fib();
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_loop();
        test_abort();
        test_async_reset();
        test_err();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
